// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, widths and the arbiter FSM state encoding.
package alu_pkg;

  localparam int ALU_W   = 16;
  localparam int ALU_OPW = 3;

  localparam logic [ALU_OPW-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OPW-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OPW-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OPW-1:0] ALU_OR  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response channels of the two ALU requesters.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int OPW   = ALU_OPW
);
  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp0_zero;

  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_result;
  logic             rsp1_zero;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_zero
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_zero
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin winner select; rr names the preferred requester on a tie.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       rr,
  output logic [1:0] gnt
);

  assign gnt[0] = valid[0] & (~valid[1] | ~rr);
  assign gnt[1] = valid[1] & (~valid[0] |  rr);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters, round-robin, one op in flight.
// Optional grant counters when ALU_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | arbitrate, accept one request, latch ALU inputs and owner
// EXEC  | ALU settles; capture result/zero for the owner
// RESP  | present response to owner until it is consumed
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int OPW   = ALU_OPW
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  arb_state_t       state_q, state_d;
  logic             rr_q, rr_d;
  logic             owner_q, owner_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic [1:0]       rsp_vld_q, rsp_vld_d;

  logic [1:0]       gnt;
  logic [1:0]       req_hs;
  logic             rsp_hs;

  rr_arb2 u_rr_arb2 (
    .valid ({bus.req1_valid, bus.req0_valid}),
    .rr    (rr_q),
    .gnt   (gnt)
  );

  assign bus.req0_ready = (state_q == IDLE) & gnt[0];
  assign bus.req1_ready = (state_q == IDLE) & gnt[1];

  assign req_hs[0] = bus.req0_valid & bus.req0_ready;
  assign req_hs[1] = bus.req1_valid & bus.req1_ready;

  // Only the owner's ready matters; the other requester's is ignored.
  assign rsp_hs = owner_q ? (rsp_vld_q[1] & bus.rsp1_ready)
                          : (rsp_vld_q[0] & bus.rsp0_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      owner_q   <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      rsp_vld_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      rsp_vld_q <= rsp_vld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    zero_d    = zero_q;
    rsp_vld_d = rsp_vld_q;

    case (state_q)
      IDLE: begin
        if (|req_hs) begin
          owner_d = req_hs[1];
          op_d    = req_hs[1] ? bus.req1_op : bus.req0_op;
          a_d     = req_hs[1] ? bus.req1_a  : bus.req0_a;
          b_d     = req_hs[1] ? bus.req1_b  : bus.req0_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d     = alu_result;
        zero_d    = alu_zero;
        rsp_vld_d = owner_q ? 2'b10 : 2'b01;
        state_d   = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          rsp_vld_d = 2'b00;
          rr_d      = ~owner_q;
          state_d   = IDLE;
        end
      end
      default: begin
        rsp_vld_d = 2'b00;
        state_d   = IDLE;
      end
    endcase
  end

  assign alu_op = op_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;

  // One shared result register feeds both ports; only the owner sees valid.
  assign bus.rsp0_valid  = rsp_vld_q[0];
  assign bus.rsp1_valid  = rsp_vld_q[1];
  assign bus.rsp0_result = res_q;
  assign bus.rsp1_result = res_q;
  assign bus.rsp0_zero   = zero_q;
  assign bus.rsp1_zero   = zero_q;

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= 16'd0;
      grant_cnt1 <= 16'd0;
    end else begin
      if (req_hs[0]) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req_hs[1]) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU standing in for the parent's ALU.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_result;
  logic        alu_zero;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int errors = 0;
  int checks = 0;

  alu_arbiter_if #(.WIDTH(16), .OPW(3)) bus ();

  alu_arbiter #(.WIDTH(16), .OPW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = 16'h0000;
    case (alu_op)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      default: alu_result = 16'h0000;
    endcase
    alu_zero = (alu_result == 16'h0000);
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int idx, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    if (idx == 0) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic drop_req(input int idx);
    if (idx == 0) bus.req0_valid = 1'b0;
    else          bus.req1_valid = 1'b0;
  endtask

  task automatic set_rsp_ready(input int idx, input logic v);
    if (idx == 0) bus.rsp0_ready = v;
    else          bus.rsp1_ready = v;
  endtask

  // Called at the negedge of cycle T+1 (EXEC); response expected in cycle T+2.
  task automatic finish_op(input int idx, input logic [15:0] er, input logic ez, input string tag);
    chk({tag, "_lat"}, 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_vld"}, 32'({bus.rsp1_valid, bus.rsp0_valid}), (idx == 0) ? 32'd1 : 32'd2);
    chk({tag, "_res"}, 32'((idx == 0) ? bus.rsp0_result : bus.rsp1_result), 32'(er));
    chk({tag, "_zero"}, 32'((idx == 0) ? bus.rsp0_zero : bus.rsp1_zero), 32'(ez));
    set_rsp_ready(idx, 1'b1);
    @(posedge clk); @(negedge clk);
    set_rsp_ready(idx, 1'b0);
    chk({tag, "_done"}, 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
  endtask

  task automatic single_op(input int idx, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] er, input logic ez, input string tag);
    drive_req(idx, op, a, b);
    #1;
    chk({tag, "_rdy"}, 32'((idx == 0) ? bus.req0_ready : bus.req1_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    drop_req(idx);
    finish_op(idx, er, ez, tag);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rspv"}, 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
    chk({tag, "_res0"}, 32'(bus.rsp0_result), 32'd0);
    chk({tag, "_res1"}, 32'(bus.rsp1_result), 32'd0);
    chk({tag, "_zero"}, 32'({bus.rsp1_zero, bus.rsp0_zero}), 32'd0);
    chk({tag, "_aluop"}, 32'(alu_op), 32'd0);
    chk({tag, "_alua"}, 32'(alu_a), 32'd0);
    chk({tag, "_alub"}, 32'(alu_b), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_op = 3'b000; bus.req0_a = 16'h0; bus.req0_b = 16'h0;
    bus.req1_valid = 1'b0; bus.req1_op = 3'b000; bus.req1_a = 16'h0; bus.req1_b = 16'h0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    chk_reset_values("rst");
`ifdef ALU_ARB_STATS_EN
    chk("rst_cnt0", 32'(grant_cnt0), 32'd0);
    chk("rst_cnt1", 32'(grant_cnt1), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Simultaneous pair right after reset: rr=0, req0 first
    drive_req(0, ALU_AND, 16'hF0F0, 16'h0FF0);
    drive_req(1, ALU_OR,  16'h00F0, 16'h0F00);
    #1;
    chk("pair1_grant", 32'({bus.req1_ready, bus.req0_ready}), 32'd1);
    @(posedge clk); @(negedge clk);
    drop_req(0);
    chk("pair1_busy", 32'(bus.req1_ready), 32'd0);
    finish_op(0, 16'h00F0, 1'b0, "pair1_a");
    chk("pair1_b_rdy", 32'(bus.req1_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    drop_req(1);
    finish_op(1, 16'h0FF0, 1'b0, "pair1_b");

    // Single ADD on req0 (rr becomes 1 afterwards)
    single_op(0, ALU_ADD, 16'h0003, 16'h0004, 16'h0007, 1'b0, "add");

    // Second simultaneous pair: rr=1, req1 first
    drive_req(0, ALU_SUB, 16'h0000, 16'h0001);
    drive_req(1, ALU_SUB, 16'h0005, 16'h0005);
    #1;
    chk("pair2_grant", 32'({bus.req1_ready, bus.req0_ready}), 32'd2);
    @(posedge clk); @(negedge clk);
    drop_req(1);
    finish_op(1, 16'h0000, 1'b1, "sub_eq");
    chk("pair2_b_rdy", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    drop_req(0);
    finish_op(0, 16'hFFFF, 1'b0, "sub_wrap");

    // Backpressure on rsp0 with req1 waiting; 0x8000+0x8000 wraps to 0
    drive_req(0, ALU_ADD, 16'h8000, 16'h8000);
    #1;
    chk("bp_rdy", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    drop_req(0);
    drive_req(1, ALU_OR, 16'h1234, 16'h0001);
    chk("bp_exec_hold", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd1);
      chk("bp_res", 32'(bus.rsp0_result), 32'h0000);
      chk("bp_zero", 32'(bus.rsp0_zero), 32'd1);
      chk("bp_hold", 32'(bus.req1_ready), 32'd0);
      @(posedge clk); @(negedge clk);
    end
    bus.rsp0_ready = 1'b1;
    #1;
    chk("bp_hs_hold", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    bus.rsp0_ready = 1'b0;
    chk("bp_accept", 32'(bus.req1_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    drop_req(1);
    finish_op(1, 16'h1235, 1'b0, "bp_or");

    // Undefined op code yields 0 / zero
    single_op(1, 3'b101, 16'h1234, 16'h5678, 16'h0000, 1'b1, "op101");
    // Leaves rr=1 before the reset test
    single_op(0, ALU_AND, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, "and_zero");

    // Reset while in EXEC
    drive_req(1, ALU_ADD, 16'h0001, 16'h0001);
    #1;
    chk("mrst_rdy", 32'(bus.req1_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    drop_req(1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk_reset_values("mrst");
`ifdef ALU_ARB_STATS_EN
    chk("mrst_cnt1", 32'(grant_cnt1), 32'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mrst_norsp", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
    end
    drive_req(0, ALU_ADD, 16'h0002, 16'h0003);
    drive_req(1, ALU_SUB, 16'h0010, 16'h0001);
    #1;
    chk("mrst_rr0", 32'({bus.req1_ready, bus.req0_ready}), 32'd1);
    @(posedge clk); @(negedge clk);
    drop_req(0);
    finish_op(0, 16'h0005, 1'b0, "post_rst");
    chk("post_rst_b_rdy", 32'(bus.req1_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    drop_req(1);
    finish_op(1, 16'h000F, 1'b0, "post_rst_b");
`ifdef ALU_ARB_STATS_EN
    chk("cnt0_after", 32'(grant_cnt0), 32'd1);
    chk("cnt1_after", 32'(grant_cnt1), 32'd1);

    // 65536 req0 grants from reset wrap the counter to zero
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    begin
      int grants = 0;
      int cycles = 0;
      drive_req(0, ALU_ADD, 16'h0001, 16'h0001);
      bus.rsp0_ready = 1'b1;
      while (grants < 65536 && cycles < 300000) begin
        if (bus.req0_ready) grants++;
        @(posedge clk); @(negedge clk);
        cycles++;
      end
      drop_req(0);
      repeat (3) @(negedge clk);
      bus.rsp0_ready = 1'b0;
      chk("wrap_grants", 32'(grants), 32'd65536);
      chk("wrap_cnt0", 32'(grant_cnt0), 32'd0);
      chk("wrap_cnt1", 32'(grant_cnt1), 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
